// File: rtl/poly_challenge_mul.sv
// poly_challenge_mul: sparse negacyclic product c*s in Z[x]/(x^N+1).
// The challenge c has coefficients in {-1,0,+1}. Its index is scanned once,
// and every nonzero term adds or subtracts a rotated copy of s into an
// accumulator array.
// Optional feature macro: POLY_CHALLENGE_MUL_MODQ_EN. When it is defined, the
// accumulators use modular add/sub in [0,Q). When it is undefined, the
// accumulators use plain 32-bit wrap-around arithmetic.
module poly_challenge_mul #(
  parameter int          N = 256,
  parameter logic [31:0] Q = 32'd8380417
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [N*32-1:0] c_in,
  input  logic [N*32-1:0] s_in,
  output logic [N*32-1:0] p_out,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int LOGN = $clog2(N);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  // Decoded challenge term codes
  localparam logic [1:0] C_ZERO  = 2'b00;
  localparam logic [1:0] C_PLUS  = 2'b01;
  localparam logic [1:0] C_MINUS = 2'b10;
  localparam logic [1:0] C_BAD   = 2'b11;

  typedef enum logic [1:0] {IDLE, SCAN, ACC, OUT} state_t;

  state_t          state;
  logic [1:0]      c_code [N];
  logic [31:0]     s_reg  [N];
  logic [31:0]     acc    [N];
  logic [LOGN-1:0] i_cnt;
  logic [LOGN-1:0] j_cnt;
  logic            neg_sign;

  logic [LOGN:0]   ij_sum;
  logic [LOGN-1:0] k_idx;
  logic            sub_op;
  logic [31:0]     s_cur;
  logic [31:0]     acc_cur;
  logic [31:0]     acc_next;

  // c is kept as a 2-bit code per term. Only the sign matters once decoded.
  function automatic logic [1:0] decode(input logic [31:0] v);
    if (v == 32'd0)
      return C_ZERO;
    else if (v == 32'd1)
      return C_PLUS;
    else if (v == 32'hFFFF_FFFF || v == Q - 32'd1)
      return C_MINUS;
    else
      return C_BAD;
  endfunction

  // Target index and effective sign for the current ACC step.
  // Wrapping past x^N flips the sign of the term.
  always_comb begin
    ij_sum  = {1'b0, i_cnt} + {1'b0, j_cnt};
    k_idx   = ij_sum[LOGN-1:0];
    sub_op  = neg_sign ^ ij_sum[LOGN];
    s_cur   = s_reg[i_cnt];
    acc_cur = acc[k_idx];
  end

`ifdef POLY_CHALLENGE_MUL_MODQ_EN
  logic [32:0] sum_w;
  logic [32:0] diff_w;

  // Modular update: add then conditionally subtract Q, or subtract then
  // conditionally add Q back.
  always_comb begin
    sum_w  = {1'b0, acc_cur} + {1'b0, s_cur};
    diff_w = {1'b0, acc_cur} - {1'b0, s_cur};
    if (sub_op)
      acc_next = diff_w[32] ? (diff_w[31:0] + Q) : diff_w[31:0];
    else
      acc_next = (sum_w >= {1'b0, Q}) ? (sum_w[31:0] - Q) : sum_w[31:0];
  end
`else
  // Plain 32-bit two's-complement update with wrap-around.
  always_comb begin
    acc_next = sub_op ? (acc_cur - s_cur) : (acc_cur + s_cur);
  end
`endif

  // Control FSM and all datapath registers. Outputs are registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      i_cnt    <= '0;
      j_cnt    <= '0;
      neg_sign <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      p_out    <= '0;
      for (int n = 0; n < N; n++) begin
        c_code[n] <= C_ZERO;
        s_reg[n]  <= '0;
        acc[n]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int n = 0; n < N; n++) begin
              c_code[n] <= decode(c_in[32*n +: 32]);
              s_reg[n]  <= s_in[32*n +: 32];
              acc[n]    <= '0;
            end
            i_cnt <= '0;
            j_cnt <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            state <= SCAN;
          end
        end
        SCAN: begin
          case (c_code[j_cnt])
            C_PLUS: begin
              neg_sign <= 1'b0;
              i_cnt    <= '0;
              state    <= ACC;
            end
            C_MINUS: begin
              neg_sign <= 1'b1;
              i_cnt    <= '0;
              state    <= ACC;
            end
            default: begin
              if (c_code[j_cnt] == C_BAD)
                err <= 1'b1;
              if (j_cnt == LAST)
                state <= OUT;
              else
                j_cnt <= j_cnt + 1'b1;
            end
          endcase
        end
        ACC: begin
          acc[k_idx] <= acc_next;
          if (i_cnt == LAST) begin
            if (j_cnt == LAST) begin
              state <= OUT;
            end else begin
              j_cnt <= j_cnt + 1'b1;
              state <= SCAN;
            end
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        OUT: begin
          for (int n = 0; n < N; n++)
            p_out[32*n +: 32] <= acc[n];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_challenge_mul.sv
// tb_poly_challenge_mul: directed self-checking bench for poly_challenge_mul.
// Expected products come from hand-derived closed forms for each vector.
module tb_poly_challenge_mul;

  localparam int          N      = 256;
  localparam logic [31:0] Q      = 32'd8380417;
  localparam int          BUDGET = 20000;

  logic            clock;
  logic            reset;
  logic            start;
  logic [N*32-1:0] c_in;
  logic [N*32-1:0] s_in;
  logic [N*32-1:0] p_out;
  logic            busy;
  logic            done;
  logic            err;

  logic [N*32-1:0] c_vec;
  logic [N*32-1:0] s_vec;
  logic [31:0]     exp_p [N];
  int              sv    [N];
  int              cycles;
  int              check_count;
  int              error_count;

  poly_challenge_mul #(.N(N), .Q(Q)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .c_in  (c_in),
    .s_in  (s_in),
    .p_out (p_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // Free-running clock with a 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pulse start for a single sampling edge, then confirm the block went busy.
  task automatic applyStimulus(input logic [N*32-1:0] c, input logic [N*32-1:0] s);
    @(negedge clock);
    c_in  = c;
    s_in  = s;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Count edges until done rises. A nonzero pulse_at re-pulses start with
  // junk c at that cycle.
  task automatic waitDone(input int pulse_at);
    cycles = 0;
    while (!done && cycles < BUDGET) begin
      @(posedge clock);
      #1;
      cycles++;
      if (pulse_at != 0 && cycles == pulse_at) begin
        c_in  = '1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (cycles >= BUDGET)
      checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Compare every product coefficient against the expected array.
  task automatic compareAll(input string name);
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("%s p[%0d]", name, k), p_out[32*k +: 32], exp_p[k]);
  endtask

  // Fill s with the ramp s[k] = k+1.
  task automatic rampS();
    for (int k = 0; k < N; k++)
      s_vec[32*k +: 32] = 32'(k + 1);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    start       = 1'b0;
    c_in        = '0;
    s_in        = '0;
    reset       = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset err",  {31'd0, err},  32'd0);
    checkOutput("reset p[0]", p_out[31:0], 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Identity term: c[0]=1, so the product equals s.
    rampS();
    c_vec = '0;
    c_vec[31:0] = 32'd1;
    applyStimulus(c_vec, s_vec);
    waitDone(0);
    checkOutput("identity latency", 32'(cycles), 32'd513);
    checkOutput("identity err", {31'd0, err}, 32'd0);
    checkOutput("identity busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < N; k++) exp_p[k] = 32'(k + 1);
    compareAll("identity");

    // Shift by x: the top coefficient wraps to -256. A start re-pulsed
    // mid-run must be ignored.
    c_vec = '0;
    c_vec[32*1 +: 32] = 32'd1;
    applyStimulus(c_vec, s_vec);
    waitDone(50);
    checkOutput("shift latency", 32'(cycles), 32'd513);
    exp_p[0] = 32'hFFFF_FF00;
    for (int k = 1; k < N; k++) exp_p[k] = 32'(k);
    compareAll("shift");

    // -x^255 encoded as all-ones: p[255]=-1, p[k]=k+2 elsewhere.
    c_vec = '0;
    c_vec[32*255 +: 32] = 32'hFFFF_FFFF;
    applyStimulus(c_vec, s_vec);
    waitDone(0);
    exp_p[255] = 32'hFFFF_FFFF;
    for (int k = 0; k < N - 1; k++) exp_p[k] = 32'(k + 2);
    compareAll("negwrap_ones");

    // The same term encoded as Q-1 gives an identical product.
    c_vec[32*255 +: 32] = Q - 32'd1;
    applyStimulus(c_vec, s_vec);
    waitDone(0);
    checkOutput("negwrap_q err", {31'd0, err}, 32'd0);
    compareAll("negwrap_q");

    // Illegal c[3]=2 raises err and contributes nothing beyond the identity term.
    c_vec = '0;
    c_vec[31:0]       = 32'd1;
    c_vec[32*3 +: 32] = 32'd2;
    applyStimulus(c_vec, s_vec);
    waitDone(0);
    checkOutput("illegal err", {31'd0, err}, 32'd1);
    checkOutput("illegal latency", 32'(cycles), 32'd513);
    for (int k = 0; k < N; k++) exp_p[k] = 32'(k + 1);
    compareAll("illegal");

    // Small signed s in [-2,2] with c = 1 - x^128:
    // p[k] = s[k]+s[k+128] for k<128, and p[k] = s[k]-s[k-128] otherwise.
    for (int k = 0; k < N; k++) begin
      sv[k] = (k % 5) - 2;
      s_vec[32*k +: 32] = 32'(sv[k]);
    end
    c_vec = '0;
    c_vec[31:0]         = 32'd1;
    c_vec[32*128 +: 32] = 32'hFFFF_FFFF;
    applyStimulus(c_vec, s_vec);
    waitDone(0);
    checkOutput("mixed latency", 32'(cycles), 32'd769);
    checkOutput("mixed err", {31'd0, err}, 32'd0);
    for (int k = 0; k < N; k++)
      exp_p[k] = (k < 128) ? 32'(sv[k] + sv[k + 128]) : 32'(sv[k] - sv[k - 128]);
    compareAll("mixed");

    // All-zero c: the previous product is held while busy, then p goes to 0
    // after 257 cycles.
    c_vec = '0;
    applyStimulus(c_vec, s_vec);
    checkOutput("hold p[0]", p_out[31:0], exp_p[0]);
    checkOutput("hold done", {31'd0, done}, 32'd0);
    waitDone(0);
    checkOutput("zero latency", 32'(cycles), 32'd257);
    for (int k = 0; k < N; k++) exp_p[k] = 32'd0;
    compareAll("zero");

    // Reset during ACC aborts at once and clears the outputs.
    rampS();
    c_vec = '0;
    c_vec[31:0] = 32'd1;
    applyStimulus(c_vec, s_vec);
    repeat (101) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort p[5]", p_out[32*5 +: 32], 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Fresh run after the abort with c = 1 - x^2:
    // p[0]=1+255, p[1]=2+256, and p[k]=2 elsewhere.
    c_vec[32*2 +: 32] = 32'hFFFF_FFFF;
    applyStimulus(c_vec, s_vec);
    waitDone(0);
    checkOutput("fresh latency", 32'(cycles), 32'd769);
    exp_p[0] = 32'd256;
    exp_p[1] = 32'd258;
    for (int k = 2; k < N; k++) exp_p[k] = 32'd2;
    compareAll("fresh");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
